// File: rtl/rv_trace_encoder.sv
// Trace record producer: samples core PC/instruction each enabled cycle, stamps a cycle count,
// drops stall repeats and buffers records in a FWFT FIFO. Define TRACE_WINDOW_EN for head/tail capture window.
module rv_trace_encoder #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HEAD_CYCLES = 100,
    parameter int TAIL_START  = 9990
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        trace_en,
    input  logic [31:0]                 pc_in,
    input  logic [31:0]                 instr_in,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [31:0]                 trace_pc,
    output logic [31:0]                 trace_instr,
    output logic [31:0]                 trace_cycle,
    output logic                        trace_ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic        ovf;
        logic [31:0] cycle;
        logic [31:0] instr;
        logic [31:0] pc;
    } rec_t;

    logic [31:0]   cycle_cnt, stamp, last_pc;
    logic          last_vld, in_win, cand_in, cand_vld;
    rec_t          cand, wr_rec, head;
    rec_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          ovf_pending, full, push, pop, drop;

    assign stamp = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 32'd1;

`ifdef TRACE_WINDOW_EN
    assign in_win = (stamp <= 32'(HEAD_CYCLES)) || (stamp >= 32'(TAIL_START));
`else
    logic unused_window;
    assign unused_window = ^{HEAD_CYCLES, TAIL_START};
    assign in_win        = 1'b1;
`endif

    // Stall repeats and out-of-window cycles still advance the counter and refresh last_pc.
    assign cand_in = trace_en && (!last_vld || (pc_in != last_pc)) && in_win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            last_pc   <= '0;
            last_vld  <= 1'b0;
            cand_vld  <= 1'b0;
            cand      <= '0;
        end else begin
            cand_vld <= cand_in;
            if (trace_en) begin
                cycle_cnt <= stamp;
                last_pc   <= pc_in;
                last_vld  <= 1'b1;
            end
            if (cand_in)
                cand <= '{ovf: 1'b0, cycle: stamp, instr: instr_in, pc: pc_in};
        end
    end

    assign trace_valid = (fifo_level != '0);
    assign full        = (fifo_level == LW'(FIFO_DEPTH));
    assign pop         = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without a pop.
    assign push        = cand_vld && (!full || pop);
    assign drop        = cand_vld && full && !pop;

    always_comb begin
        wr_rec     = cand;
        wr_rec.ovf = ovf_pending;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            ovf_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                ovf_pending <= 1'b0;
            end else if (drop) begin
                ovf_pending <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    assign head        = mem[rd_ptr];
    assign trace_pc    = trace_valid ? head.pc    : '0;
    assign trace_instr = trace_valid ? head.instr : '0;
    assign trace_cycle = trace_valid ? head.cycle : '0;
    assign trace_ovf   = trace_valid ? head.ovf   : 1'b0;

endmodule
